// File: rtl/ub_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ub_port_arbiter: round-robin sharing of the unified buffer's write and   |
// | read ports between two requesters each, with same-address RAW stall.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ub_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int MUL_SIZE = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr0_req_i,
    input  logic                       wr1_req_i,
    input  logic [ADDR_W-1:0]          wr0_addr_i,
    input  logic [ADDR_W-1:0]          wr1_addr_i,
    input  logic [DATA_W*MUL_SIZE-1:0] wr0_data_i,
    input  logic [DATA_W*MUL_SIZE-1:0] wr1_data_i,
    output logic                       wr0_gnt_o,
    output logic                       wr1_gnt_o,
    input  logic                       rd0_req_i,
    input  logic                       rd1_req_i,
    input  logic [ADDR_W-1:0]          rd0_addr_i,
    input  logic [ADDR_W-1:0]          rd1_addr_i,
    output logic                       rd0_gnt_o,
    output logic                       rd1_gnt_o,
    output logic                       rd0_valid_o,
    output logic                       rd1_valid_o,
    output logic [DATA_W*MUL_SIZE-1:0] rd_data_o,
    output logic                       ub_write_o,
    output logic                       ub_read_o,
    output logic [ADDR_W-1:0]          ub_addr_wr_o,
    output logic [ADDR_W-1:0]          ub_addr_rd_o,
    output logic [DATA_W*MUL_SIZE-1:0] ub_data_o,
    input  logic [DATA_W*MUL_SIZE-1:0] ub_data_i,
    output logic [CNT_W-1:0]           hazard_cnt_o
);

    localparam int ROW_W = DATA_W * MUL_SIZE;

    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_gnt0, wr_gnt1, wr_any;
    logic              rd_cand0, rd_cand1, rd_cand_any;
    logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel;
    logic [ROW_W-1:0]  wr_data_sel;
    logic              hazard;

    logic              ub_write_q, ub_read_q;
    logic [ADDR_W-1:0] ub_addr_wr_q, ub_addr_rd_q;
    logic [ROW_W-1:0]  ub_data_q;
    logic              tag1_id_q;
    logic              rd0_valid_q, rd1_valid_q;
    logic [ROW_W-1:0]  rd_hold_q;
    logic [CNT_W-1:0]  hazard_cnt_q;

    // Pointer value 0 favours requester 0, 1 favours requester 1.
    assign wr_gnt0     = wr0_req_i & (~wr1_req_i | ~wr_ptr_q);
    assign wr_gnt1     = wr1_req_i & (~wr0_req_i |  wr_ptr_q);
    assign wr_any      = wr_gnt0 | wr_gnt1;
    assign wr_addr_sel = wr_gnt1 ? wr1_addr_i : wr0_addr_i;
    assign wr_data_sel = wr_gnt1 ? wr1_data_i : wr0_data_i;

    assign rd_cand0    = rd0_req_i & (~rd1_req_i | ~rd_ptr_q);
    assign rd_cand1    = rd1_req_i & (~rd0_req_i |  rd_ptr_q);
    assign rd_cand_any = rd_cand0 | rd_cand1;
    assign rd_addr_sel = rd_cand1 ? rd1_addr_i : rd0_addr_i;

    // A read to the row being written this cycle waits one cycle so it sees the new data.
    assign hazard = wr_any & rd_cand_any & (wr_addr_sel == rd_addr_sel);

    assign wr0_gnt_o = wr_gnt0;
    assign wr1_gnt_o = wr_gnt1;
    assign rd0_gnt_o = rd_cand0 & ~hazard;
    assign rd1_gnt_o = rd_cand1 & ~hazard;

    assign wr_ptr_d = (wr0_req_i & wr1_req_i) ? ~wr_ptr_q : wr_ptr_q;
    assign rd_ptr_d = (rd0_req_i & rd1_req_i & ~hazard) ? ~rd_ptr_q : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            ub_write_q   <= 1'b0;
            ub_addr_wr_q <= '0;
            ub_data_q    <= '0;
            ub_read_q    <= 1'b0;
            ub_addr_rd_q <= '0;
            tag1_id_q    <= 1'b0;
            rd0_valid_q  <= 1'b0;
            rd1_valid_q  <= 1'b0;
            rd_hold_q    <= '0;
            hazard_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ub_write_q <= wr_any;
            if (wr_any) begin
                ub_addr_wr_q <= wr_addr_sel;
                ub_data_q    <= wr_data_sel;
            end
            ub_read_q <= rd_cand_any & ~hazard;
            if (rd_cand_any & ~hazard) begin
                ub_addr_rd_q <= rd_addr_sel;
                tag1_id_q    <= rd_cand1;
            end
            rd0_valid_q <= ub_read_q & ~tag1_id_q;
            rd1_valid_q <= ub_read_q &  tag1_id_q;
            if (rd0_valid_q | rd1_valid_q) begin
                rd_hold_q <= ub_data_i;
            end
            if (hazard && (hazard_cnt_q != {CNT_W{1'b1}})) begin
                hazard_cnt_q <= hazard_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ub_write_o   = ub_write_q;
    assign ub_addr_wr_o = ub_addr_wr_q;
    assign ub_data_o    = ub_data_q;
    assign ub_read_o    = ub_read_q;
    assign ub_addr_rd_o = ub_addr_rd_q;
    assign rd0_valid_o  = rd0_valid_q;
    assign rd1_valid_o  = rd1_valid_q;
    assign rd_data_o    = (rd0_valid_q | rd1_valid_q) ? ub_data_i : rd_hold_q;
    assign hazard_cnt_o = hazard_cnt_q;

endmodule
`default_nettype wire

// File: doc/ub_port_arbiter.md
Name: ub_port_arbiter

Overview:
- Shares the unified buffer's single write port and single read port between two write requesters and two read requesters.
  - Write requesters: wr0 = host load DMA, wr1 = activation writeback.
  - Read requesters: rd0 = systolic array feeder, rd1 = host readout.
- Per-port round-robin arbitration, registered command stage, read-data return with per-requester valid strobe, and a same-address read-after-write stall.
- Sits between the requesters and unified_buffer; drives its read_i/write_i/addr/data pins directly.

Parameters:
- ADDR_W, 12, unified buffer address width (4096 rows).
- DATA_W, ACT_WIDTH+1, bits per lane (tpu_package); MUL_SIZE lanes per row.
- CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- wr0_req_i / wr1_req_i  in  1  write request
- wr0_addr_i / wr1_addr_i  in  ADDR_W  write row address
- wr0_data_i / wr1_data_i  in  DATA_W x MUL_SIZE  write row data
- wr0_gnt_o / wr1_gnt_o  out  1  write accepted this cycle
- rd0_req_i / rd1_req_i  in  1  read request
- rd0_addr_i / rd1_addr_i  in  ADDR_W  read row address
- rd0_gnt_o / rd1_gnt_o  out  1  read accepted this cycle
- rd0_valid_o / rd1_valid_o  out  1  rd_data_o holds this requester's row
- rd_data_o  out  DATA_W x MUL_SIZE  read return data (shared)
- ub_write_o, ub_read_o  out  1  to unified_buffer write_i/read_i
- ub_addr_wr_o, ub_addr_rd_o  out  ADDR_W  to unified_buffer addresses
- ub_data_o  out  DATA_W x MUL_SIZE  to unified_buffer_in
- ub_data_i  in  DATA_W x MUL_SIZE  from unified_buffer_out
- hazard_cnt_o  out  CNT_W  saturating count of RAW stall cycles

Behaviour:
- Reset (rst_i low, async): all outputs 0, both round-robin pointers favour requester 0, command and return pipelines cleared. Any in-flight read is dropped; no rd*_valid_o may assert for a read accepted before reset.
- Handshake:
  - Requester holds req/addr/data stable until it sees gnt in the same cycle.
  - gnt is combinational from req and pointer state.
  - One grant per port per cycle; at most one wr*_gnt_o and one rd*_gnt_o high.
- Arbitration, each port independently:
  - Single requester: granted immediately.
  - Both requesting: pointer holder wins; pointer then moves to the other requester.
  - Pointer does not move on cycles with no contention.
- Write path, request granted in cycle N:
  - Cycle N+1: ub_write_o=1 with registered addr/data.
  - Row is written at the end of N+1.
  - ub_write_o=0 in any cycle with no write grant in the previous cycle.
- Read path, request granted in cycle N:
  - Cycle N+1: ub_read_o=1, ub_addr_rd_o registered.
  - Cycle N+2: rd_data_o = ub_data_i (pass-through) and the granted requester's rd*_valid_o=1 for exactly one cycle.
  - Requester ID is carried in a 2-stage tag pipeline.
  - Back-to-back reads give one valid per cycle, in grant order.
- RAW hazard:
  - Trigger: in cycle N a write grant and a read grant would target the same address.
  - The read grant is withheld in N (rd gnt=0, read pointer unchanged); the write proceeds.
  - In N+1 the read re-arbitrates normally and returns the newly written data.
  - hazard_cnt_o increments by 1 per stalled cycle and saturates at all-ones.
  - Different addresses: both granted in the same cycle.
- Read-only and write-only cycles are unaffected by the hazard rule.
- rd_data_o holds its last value when no valid is asserted. The bench checks data only under valid.

Test Plan:
- Reset mid-read: rd0 granted, rst_i low next cycle -> no rd0_valid_o ever follows; all outputs 0, hazard_cnt_o=0.
- Single write then read: wr0 addr 0x010 data lanes=0x5A granted cycle 0, ub_write_o at cycle 1; rd1 addr 0x010 granted cycle 2 -> rd1_valid_o at cycle 4 with all lanes 0x5A.
- Contention, write port: wr0 and wr1 requesting continuously for 4 cycles -> grants alternate wr0,wr1,wr0,wr1; ub_addr_wr_o follows the same order one cycle later.
- Contention, read port: rd0 and rd1 requesting continuously -> valids alternate rd0,rd1 at 2-cycle latency, one per cycle, no gaps.
- RAW stall: wr1 addr 0x0FF data 0x11 and rd0 addr 0x0FF in the same cycle (old row 0x22):
  - rd0_gnt_o=0 that cycle and hazard_cnt_o becomes 1.
  - rd0 is granted the next cycle and returns 0x11.
  - Repeat with rd0 addr 0x100 -> both granted the same cycle, no count change.
- Saturation: force 2^CNT_W+3 hazard cycles -> hazard_cnt_o holds 0xFFFF.
